// File: rtl/mc_core.sv
// Multicycle 16-register core with a unified, ready-handshaked instruction/data memory port.
// MC_CORE_CONDEXEC_EN enables EQ/NE condition evaluation on IR[31:28]; otherwise every instruction executes.
module mc_core #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [3:0]       flags,
  output logic [2:0]       state,
  output logic [WIDTH-1:0] dataout
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  logic [27:0]      ir;
  logic [WIDTH-1:0] a, b, aluout, mdr;
  logic [WIDTH-1:0] rf [16];
  logic [WIDTH-1:0] pc4, rn_val, rm_val, rd_val, op2, res, maddr, boff;
  logic [WIDTH:0]   sum, diff;
  logic             c_out, v_out, cond_ok;
  logic [1:0]       op;
  logic [3:0]       rd;

  assign op  = ir[27:26];
  assign rd  = ir[15:12];
  assign pc4 = pc + WIDTH'(4);

  // Index 15 is the pc view (instruction address + 8), never the storage slot.
  always_comb begin
    rn_val = (ir[19:16] == 4'hF) ? pc4 : rf[ir[19:16]];
    rm_val = (ir[3:0]   == 4'hF) ? pc4 : rf[ir[3:0]];
    rd_val = (rd        == 4'hF) ? pc4 : rf[rd];
  end

  always_comb begin
    op2   = ir[25] ? {{(WIDTH-8){1'b0}}, ir[7:0]} : b;
    sum   = {1'b0, a} + {1'b0, op2};
    diff  = {1'b0, a} - {1'b0, op2};
    res   = '0;
    c_out = 1'b0;
    v_out = 1'b0;
    case (ir[24:21])
      CMD_ADD: begin
        res   = sum[WIDTH-1:0];
        c_out = sum[WIDTH];
        v_out = (a[WIDTH-1] == op2[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      CMD_SUB: begin
        res   = diff[WIDTH-1:0];
        c_out = ~diff[WIDTH];
        v_out = (a[WIDTH-1] != op2[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      CMD_AND: res = a & op2;
      CMD_ORR: res = a | op2;
      default: res = '0;
    endcase
  end

  assign maddr = a + {{(WIDTH-12){1'b0}}, ir[11:0]};
  assign boff  = {{(WIDTH-26){ir[23]}}, ir[23:0], 2'b00};

`ifdef MC_CORE_CONDEXEC_EN
  logic [3:0] cond;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cond <= 4'h0;
    else if (state == FETCH && mem_ready) cond <= mem_rdata[31:28];
  end

  always_comb begin
    case (cond)
      4'b0000: cond_ok = flags[2];
      4'b0001: cond_ok = ~flags[2];
      default: cond_ok = 1'b1;
    endcase
  end
`else
  assign cond_ok = 1'b1;
`endif

  assign mem_req   = (state == FETCH) || (state == MEM);
  assign mem_we    = (state == MEM) && !ir[20];
  assign mem_addr  = (state == MEM) ? aluout : pc;
  assign mem_wdata = rd_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      flags   <= 4'h0;
      dataout <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      aluout  <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir    <= mem_rdata[27:0];
          pc    <= pc4;
          state <= DECODE;
        end
        DECODE: begin
          a     <= rn_val;
          b     <= rm_val;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          if (cond_ok) begin
            case (op)
              OP_DP: begin
                aluout  <= res;
                dataout <= res;
                if (ir[20]) flags <= {res[WIDTH-1], res == '0, c_out, v_out};
                state   <= WB;
              end
              OP_MEM: begin
                aluout  <= maddr;
                dataout <= maddr;
                state   <= MEM;
              end
              OP_B:    pc <= pc4 + boff;
              default: ;
            endcase
          end
        end
        MEM: if (mem_ready) begin
          mdr   <= mem_rdata;
          state <= ir[20] ? WB : FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (state == WB && rd != 4'hF) begin
      rf[rd] <= (op == OP_MEM) ? mdr : aluout;
    end
  end

endmodule

// File: tb/tb_mc_core.sv
// Randomized bench for mc_core against an instruction-level reference model with a bench-side memory.
module tb_mc_core;
  localparam int          W   = 32;
  localparam logic [31:0] RPC = 32'h100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req, mem_we, mem_ready;
  logic [W-1:0]  mem_addr, mem_wdata, mem_rdata, pc, dataout;
  logic [3:0]    flags;
  logic [2:0]    state;

  always #5 clk = ~clk;

  mc_core #(.WIDTH(W), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .flags(flags), .state(state), .dataout(dataout)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          last_cycles;
  logic [31:0] mr [16];
  logic [31:0] dmem [64];
  logic [31:0] mpc, mdout;
  logic [3:0]  mfl;
  logic [3:0]  cmds [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] src(input logic [3:0] i);
    return (i == 4'hF) ? mpc + 32'd8 : mr[i];
  endfunction

  function automatic bit cond_pass(input logic [3:0] c);
`ifdef MC_CORE_CONDEXEC_EN
    if (c == 4'b0000) return mfl[2];
    if (c == 4'b0001) return !mfl[2];
`endif
    return (c == c);
  endfunction

  function automatic logic [31:0] enc_dp(input logic [3:0] c, input logic i, input logic [3:0] cmd,
                                         input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                         input logic [11:0] op2);
    return {c, 2'b00, i, cmd, s, rn, rd, op2};
  endfunction

  function automatic logic [31:0] enc_mem(input logic [3:0] c, input logic l, input logic [3:0] rn,
                                          input logic [3:0] rd, input logic [11:0] imm);
    return {c, 2'b01, 1'b0, 4'b0000, l, rn, rd, imm};
  endfunction

  function automatic logic [31:0] enc_b(input logic [3:0] c, input logic [23:0] imm);
    return {c, 2'b10, 2'b00, imm};
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 16; i++) mr[i] = 32'h0;
    mpc = RPC; mfl = 4'h0; mdout = 32'h0;
  endtask

  // Executes one instruction on both the DUT and the model, checking the bus traffic on the way.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw);
    logic [31:0] a, op2, res, eaddr, ewd, enpc, edout, wr_val;
    logic [3:0]  efl, rd;
    longint      ua, ub;
    bit          c, v, is_mem, is_st, wr_en;
    int          exl, cyc, mwl;
    rd = ins[15:12];
    a = src(ins[19:16]);
    op2 = ins[25] ? {24'h0, ins[7:0]} : src(ins[3:0]);
    ua = longint'(a); ub = longint'(op2);
    exl = 3; enpc = mpc + 32'd4; efl = mfl; edout = mdout;
    is_mem = 0; is_st = 0; wr_en = 0; wr_val = 0; eaddr = 0; ewd = 0; res = 0; c = 0; v = 0;
    if (cond_pass(ins[31:28])) begin
      case (ins[27:26])
        2'b00: begin
          case (ins[24:21])
            4'b0100: begin res = a + op2; c = ((ua + ub) >> 32) != 0;
                           v = (a[31] == op2[31]) && (res[31] != a[31]); end
            4'b0010: begin res = a - op2; c = ua >= ub;
                           v = (a[31] != op2[31]) && (res[31] != a[31]); end
            4'b0000: res = a & op2;
            default: res = a | op2;
          endcase
          if (ins[20]) efl = {res[31], res == 32'h0, c, v};
          edout = res; wr_en = 1; wr_val = res; exl = 4;
        end
        2'b01: begin
          eaddr = a + {20'h0, ins[11:0]}; edout = eaddr; is_mem = 1;
          if (ins[20]) begin wr_en = 1; wr_val = dmem[eaddr[7:2]]; exl = 5; end
          else begin is_st = 1; ewd = src(rd); exl = 4; end
        end
        2'b10: enpc = mpc + 32'd8 + {{6{ins[23]}}, ins[23:0], 2'b00};
        default: ;
      endcase
    end
    exl += fw + (is_mem ? mw : 0);

    chk("fetch_state", state, 0);
    chk("fetch_req", {mem_req, mem_we}, 2'b10);
    chk("fetch_addr", mem_addr, mpc);
    chk("pc", pc, mpc);
    cyc = 0;
    repeat (fw) begin
      mem_ready = 0; step; cyc++;
      chk("fetch_hold", {mem_req, mem_addr}, {1'b1, mpc});
    end
    mem_ready = 1; mem_rdata = ins; step; cyc++; mem_ready = 0;
    mwl = mw;
    while (state != 3'd0 && cyc < 60) begin
      if (state == 3'd3) begin
        chk("mem_req", {mem_req, mem_we}, {1'b1, is_st});
        chk("mem_addr", mem_addr, eaddr);
        if (mwl > 0) begin
          mwl--; mem_ready = 0;
        end else begin
          mem_ready = 1;
          if (mem_we) chk("st_data", mem_wdata, ewd);
          else mem_rdata = dmem[mem_addr[7:2]];
        end
      end else begin
        chk("req_idle", {mem_req, mem_we}, 2'b00);
      end
      step; cyc++; mem_ready = 0;
    end
    chk("latency", cyc, exl);
    if (wr_en && rd != 4'hF) mr[rd] = wr_val;
    if (is_st) dmem[eaddr[7:2]] = ewd;
    mfl = efl; mdout = edout; mpc = enpc;
    chk("flags", flags, mfl);
    chk("dataout", dataout, mdout);
    last_cycles = cyc;
  endtask

  function automatic logic [3:0] rand_cond();
    case ($urandom_range(0, 3))
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b1110;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic run_random(input int n);
    logic [31:0] ins;
    logic [23:0] im;
    int          off, k;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 4)
        ins = enc_dp(rand_cond(), 1'($urandom_range(0, 1)), cmds[$urandom_range(0, 3)],
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(1, 15)), 12'($urandom_range(0, 4095)));
      else if (k <= 7)
        ins = enc_mem(rand_cond(), k != 7, 4'h0, 4'($urandom_range(1, 15)),
                      {4'h0, 6'($urandom_range(0, 63)), 2'b00});
      else if (k == 8) begin
        off = int'($urandom_range(0, 6)) - 3;
        im = off[23:0];
        ins = enc_b(rand_cond(), im);
      end else
        ins = {rand_cond(), 2'b11, 26'($urandom)};
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  task automatic dump_regs;
    for (int i = 1; i < 15; i++)
      run_instr(enc_mem(4'hE, 1'b0, 4'h0, 4'(i), 12'(i * 4)), $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    mem_ready = 0; mem_rdata = '0;
    for (int i = 0; i < 64; i++) dmem[i] = $urandom;
    model_reset();
    step; step;
    chk("rst_state", state, 0);
    chk("rst_pc", pc, RPC);
    chk("rst_flags", flags, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_bus", {mem_req, mem_we, mem_addr}, {2'b10, RPC});
    reset = 0;

    run_instr(enc_dp(4'hE, 1'b1, 4'b0100, 1'b1, 4'h0, 4'h1, 12'h0FF), 0, 0);
    chk("adds_r1", dataout, 32'hFF);
    run_instr(enc_dp(4'hE, 1'b1, 4'b0010, 1'b1, 4'h1, 4'h2, 12'h0FF), 0, 0);
    chk("subs_flags", flags, 4'b0110);
    chk("subs_lat", last_cycles, 4);
    run_instr(enc_b(4'hE, 24'hFFFFFE), 0, 0);
    chk("b_self", mem_addr, 32'h108);
    run_instr(enc_b(4'hE, 24'h000001), 0, 0);
    chk("b_fwd", mem_addr, 32'h114);
    run_instr(enc_mem(4'hE, 1'b0, 4'h0, 4'h1, 12'h020), 2, 2);
    chk("str_mem", dmem[8], 32'hFF);
    run_instr(enc_mem(4'hE, 1'b1, 4'h0, 4'h3, 12'h020), 2, 2);
    chk("ldr_lat", last_cycles, 9);
    run_instr(enc_dp(4'hE, 1'b1, 4'b0100, 1'b1, 4'h0, 4'h5, 12'h001), 0, 0);
    run_instr(enc_dp(4'b0000, 1'b1, 4'b0100, 1'b0, 4'h0, 4'h4, 12'h001), 0, 0);
`ifdef MC_CORE_CONDEXEC_EN
    chk("addeq_skip_lat", last_cycles, 3);
`else
    chk("addeq_run_lat", last_cycles, 4);
`endif
    run_instr(enc_dp(4'b0001, 1'b1, 4'b0100, 1'b0, 4'h0, 4'h4, 12'h001), 0, 0);
    chk("addne_r4", dataout, 32'h1);
    dump_regs();

    run_random(200);
    dump_regs();

    mem_rdata = enc_mem(4'hE, 1'b1, 4'h0, 4'h6, 12'h024);
    mem_ready = 1; step; mem_ready = 0;
    n = 0;
    while (state != 3'd3 && n < 10) begin step; n++; end
    chk("stall_reach", state, 3);
    step;
    reset = 1; #1;
    chk("abort_state", state, 0);
    chk("abort_pc", pc, RPC);
    chk("abort_bus", {mem_req, mem_we, mem_addr}, {2'b10, RPC});
    chk("abort_flags_dout", {flags, dataout}, 36'h0);
    step; step;
    chk("abort_hold_pc", pc, RPC);
    reset = 0;
    model_reset();
    dump_regs();

    run_random(200);
    dump_regs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_core.md
MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data-path and register width; legal range 32..64; instructions stay 32 bits and are zero-extended to WIDTH.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, WIDTH), mem_wdata (output, WIDTH): the unified instruction/data memory request.
REQ-006 SHALL have ports mem_rdata (input, WIDTH) and mem_ready (input, 1): read data and access completion.
REQ-007 SHALL have ports pc (output, WIDTH), flags (output, 4, NZCV), state (output, 3, FSM encoding), dataout (output, WIDTH, last ALU result).

Function
REQ-008 SHALL be a multicycle core with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; 16 registers r0..r15.
REQ-009 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=pc, and hold them stable until mem_ready=1; on that edge: latch IR, pc<=pc+4, go to DECODE.
REQ-010 DECODE SHALL latch A<=R[IR[19:16]] and B<=R[IR[3:0]]; a source index of 15 reads pc+4 (instruction address+8).
REQ-011 Encoding SHALL be: IR[27:26] op (00 DP, 01 MEM, 10 B, 11 undefined); IR[25] immediate select; IR[24:21] cmd (0100 ADD, 0010 SUB, 0000 AND, 1100 ORR); IR[20] S for DP / L for MEM; IR[15:12] Rd.
REQ-012 The DP second operand SHALL be zero-extended imm8 when IR[25]=1, else B; MEM SHALL use address A+zero-extended imm12.
REQ-013 EXEC SHALL compute the ALU result into register ALUOut and dataout; DP goes to WB, MEM goes to MEM, B loads pc<=pc+4+(sign-extended IR[23:0]<<2) and goes to FETCH, undefined goes to FETCH with no state change.
REQ-014 For DP with S=1, flags SHALL update at the end of EXEC: N=msb, Z=(result==0), C=carry-out for ADD / not-borrow for SUB / 0 for logic, V=signed overflow for ADD/SUB / 0 for logic.
REQ-015 MEM SHALL drive mem_req=1, mem_addr=ALUOut, and mem_we=~L with mem_wdata=R[Rd], and hold them until mem_ready; a load latches mem_rdata and goes to WB, a store goes to FETCH.
REQ-016 WB SHALL write ALUOut (DP) or the load data (LDR) to R[Rd], then go to FETCH; a write with Rd=15 SHALL be discarded.
REQ-017 With zero-wait memory, latency SHALL be: DP 4 cycles, LDR 5, STR 4, B 3; each memory wait cycle adds one cycle.
REQ-018 mem_req SHALL be 0 in DECODE, EXEC and WB; mem_we SHALL be 1 only in MEM during a store.
REQ-019 Arithmetic SHALL wrap modulo 2^WIDTH; pc increments SHALL wrap at 2^WIDTH.

Reset
REQ-020 While reset=1 and asynchronously on its assertion: state=FETCH, pc=RESET_PC, flags=0, dataout=0, r0..r14=0, IR=0, mem_we=0.
REQ-021 A reset during any state, including a stalled memory access, SHALL abort the access without writing any register; fetch from RESET_PC restarts on the first clk edge after reset deasserts.

Configuration
REQ-022 Macro MC_CORE_CONDEXEC_EN defined: IR[31:28] SHALL be evaluated in EXEC: EQ(0000) runs if Z=1, NE(0001) runs if Z=0, AL(1110) always; all other codes behave as AL.
REQ-023 When a defined condition fails, the instruction SHALL go from EXEC to FETCH with no flag, register, memory or pc change beyond pc+4.
REQ-024 Macro MC_CORE_CONDEXEC_EN undefined: IR[31:28] SHALL be ignored and every instruction executes.

Verification
REQ-025 Reset with RESET_PC=0x100 -> pc=0x100, state=0, flags=0; the first mem_req addresses 0x100.
REQ-026 ADDS r1,r0,#0xFF then SUBS r2,r1,#0xFF (zero-wait memory) -> r1=0xFF, r2=0, flags=0110 (Z=1, C=1), each instruction takes 4 cycles.
REQ-027 STR r1,[r0,#0x20] then LDR r3,[r0,#0x20] with mem_ready held low 2 cycles per access -> write of 0xFF at 0x20 with mem_we=1, r3=0xFF, LDR takes 9 cycles.
REQ-028 B with imm24=0xFFFFFE at 0x108 -> next fetch at 0x108 (self-loop); with imm24=1 -> next fetch at 0x114.
REQ-029 With MC_CORE_CONDEXEC_EN and Z=0, ADDEQ r4,r0,#1 -> r4 unchanged, takes 3 cycles; ADDNE r4,r0,#1 -> r4=1.
REQ-030 Assert reset during a LDR MEM-state stall -> no register write, state=0, pc=RESET_PC.
